// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode enum and pointer/count width helpers,
// common to the synchronous and asynchronous FIFO variants.
package fifo_pkg;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Pointers carry one extra wrap bit beyond the address.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write port, combinational read port.
// Contents are deliberately not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [addr_w(DEPTH)-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [addr_w(DEPTH)-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with registered full/empty/almost flags, fill count,
// sticky overflow/underflow errors and a selectable FWFT read mode.
module sync_fifo_flagged
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int          AFULL_THRESH  = DEPTH - 2,
  parameter int          AEMPTY_THRESH = 2,
  parameter int          FWFT          = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow,
  input  logic                        clr_err
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned PTR_W  = ptr_w(DEPTH);
  localparam fifo_mode_e  MODE   = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  localparam logic [PTR_W-1:0] ONE    = 1;
  localparam logic [PTR_W-1:0] AF_LIM = AFULL_THRESH[PTR_W-1:0];
  localparam logic [PTR_W-1:0] AE_LIM = AEMPTY_THRESH[PTR_W-1:0];

  if (AFULL_THRESH <= 0 || AFULL_THRESH > int'(DEPTH)) begin : g_bad_afull
    $error("sync_fifo_flagged: AFULL_THRESH must satisfy 0 < AFULL_THRESH <= DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= int'(DEPTH)) begin : g_bad_aempty
    $error("sync_fifo_flagged: AEMPTY_THRESH must satisfy 0 <= AEMPTY_THRESH < DEPTH");
  end

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_nx, rd_ptr_nx;
  logic [PTR_W-1:0]      count_nx;
  logic                  full_nx, empty_nx;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd;

  // Accept decisions use the registered flags only, so a write at full is
  // refused even when a read frees a slot on the same edge.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_nx = wr_acc ? wr_ptr + ONE : wr_ptr;
    rd_ptr_nx = rd_acc ? rd_ptr + ONE : rd_ptr;
    count_nx  = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nx = count + ONE;
      2'b01:   count_nx = count - ONE;
      default: count_nx = count;
    endcase
    full_nx  = (wr_ptr_nx[ADDR_W] != rd_ptr_nx[ADDR_W]) &&
               (wr_ptr_nx[ADDR_W-1:0] == rd_ptr_nx[ADDR_W-1:0]);
    empty_nx = (wr_ptr_nx == rd_ptr_nx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nx;
      rd_ptr       <= rd_ptr_nx;
      count        <= count_nx;
      full         <= full_nx;
      empty        <= empty_nx;
      almost_full  <= (count_nx >= AF_LIM);
      almost_empty <= (count_nx <= AE_LIM);
    end
  end

  // Set has priority over clear when both happen in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)      overflow <= 1'b1;
      else if (clr_err)       overflow <= 1'b0;
      if (rd_en && empty)     underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (mem_rd)
  );

  if (MODE == MODE_FWFT) begin : g_fwft
    assign rd_data  = mem_rd;
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_rd;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed bench for sync_fifo_flagged: a standard and an FWFT instance share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_sync_fifo_flagged;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] s_count, f_count;

  sync_fifo_flagged #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
  );

  sync_fifo_flagged #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, errors as bits, std read-port latch.
  logic [7:0] q[$];
  bit         m_ovf = 0, m_unf = 0, m_valid = 0;
  logic [7:0] m_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      bit was_full, was_empty;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (wr_en && was_full) m_ovf = 1;
      else if (clr_err)      m_ovf = 0;
      if (rd_en && was_empty) m_unf = 1;
      else if (clr_err)       m_unf = 0;
      m_valid = 0;
      if (rd_en && !was_empty) begin
        m_data  = q.pop_front();
        m_valid = 1;
      end
      if (wr_en && !was_full) q.push_back(wr_data);
    end
  end

  always @(negedge rst) begin
    q.delete();
    m_ovf = 0; m_unf = 0; m_valid = 0; m_data = '0;
  end

  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("std_count",  32'(s_count),    32'(n));
    chk("std_full",   32'(s_full),     32'(n == DEPTH));
    chk("std_empty",  32'(s_empty),    32'(n == 0));
    chk("std_afull",  32'(s_af),       32'(n >= DEPTH - 2));
    chk("std_aempty", 32'(s_ae),       32'(n <= 2));
    chk("std_ovf",    32'(s_ovf),      32'(m_ovf));
    chk("std_unf",    32'(s_unf),      32'(m_unf));
    chk("std_valid",  32'(s_rd_valid), 32'(m_valid));
    chk("std_data",   32'(s_rd_data),  32'(m_data));
    chk("fwft_count", 32'(f_count),    32'(n));
    chk("fwft_full",  32'(f_full),     32'(n == DEPTH));
    chk("fwft_empty", 32'(f_empty),    32'(n == 0));
    chk("fwft_ovf",   32'(f_ovf),      32'(m_ovf));
    chk("fwft_unf",   32'(f_unf),      32'(m_unf));
    chk("fwft_valid", 32'(f_rd_valid), 32'(n != 0));
    if (n != 0) chk("fwft_data", 32'(f_rd_data), 32'(q[0]));
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(s_count), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_aempty", 32'(s_ae), 32'd1);
    chk("rst_full", 32'(s_full), 32'd0);
    chk("rst_valid", 32'(s_rd_valid), 32'd0);
    chk("rst_data", 32'(s_rd_data), 32'd0);
    rst = 1'b1;

    // Fill to full, then one refused write.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 5) chk("t1_afull_at5", 32'(s_af), 32'd0);
      if (i == 6) chk("t1_afull_at6", 32'(s_af), 32'd1);
    end
    chk("t1_full", 32'(s_full), 32'd1);
    chk("t1_count8", 32'(s_count), 32'd8);
    cyc(1'b1, 8'h09, 1'b0, 1'b0);
    chk("t1_ovf", 32'(s_ovf), 32'd1);
    chk("t1_count_hold", 32'(s_count), 32'd8);

    // Drain plus one read on empty.
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      if (i <= 8) begin
        chk("t2_valid", 32'(s_rd_valid), 32'd1);
        chk("t2_data", 32'(s_rd_data), 32'(i));
      end
    end
    chk("t2_empty", 32'(s_empty), 32'd1);
    chk("t2_unf", 32'(s_unf), 32'd1);
    chk("t2_valid9", 32'(s_rd_valid), 32'd0);
    chk("t2_data_hold", 32'(s_rd_data), 32'h08);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_clr", 32'(s_unf), 32'd0);

    // Steady-state streaming at count 3 across pointer wrap.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
      chk("t3_count", 32'(s_count), 32'd3);
      if (i == 0) chk("t3_first", 32'(s_rd_data), 32'h10);
      if (i == 19) chk("t3_last", 32'(s_rd_data), 32'h30);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_tail", 32'(s_rd_data), 32'h33);

    // Simultaneous write+read at full: write refused.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("t4_count7", 32'(s_count), 32'd7);
    chk("t4_ovf", 32'(s_ovf), 32'd1);
    chk("t4_rd", 32'(s_rd_data), 32'h40);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t4_clr", 32'(s_ovf), 32'd0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_last", 32'(s_rd_data), 32'h47);
    chk("t4_empty", 32'(s_empty), 32'd1);

    // FWFT presentation without rd_en.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("t5_fdata", 32'(f_rd_data), 32'hA5);
    chk("t5_fvalid", 32'(f_rd_valid), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_fdata_hold", 32'(f_rd_data), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_fempty", 32'(f_empty), 32'd1);
    chk("t5_fvalid0", 32'(f_rd_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_unf", 32'(f_unf), 32'd1);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    chk("t6_count5", 32'(s_count), 32'd5);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h60; rd_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_count0", 32'(s_count), 32'd0);
    chk("t6_empty", 32'(s_empty), 32'd1);
    chk("t6_aempty", 32'(s_ae), 32'd1);
    chk("t6_afull", 32'(s_af), 32'd0);
    chk("t6_unf", 32'(s_unf), 32'd0);
    chk("t6_fcount0", 32'(f_count), 32'd0);
    chk("t6_fvalid", 32'(f_rd_valid), 32'd0);
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    chk("t6_fdata", 32'(f_rd_data), 32'h33);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_valid", 32'(s_rd_valid), 32'd1);
    chk("t6_data", 32'(s_rd_data), 32'h33);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_empty_end", 32'(s_empty), 32'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
